// File: rtl/ppu_pkg.sv
// Shared posit types and constants for the PPU pipeline (N=16, ES=1),
// including the stage-1 record used by the rounding/encoding stage.
package ppu_pkg;

  localparam int N              = 16;
  localparam int ES             = 1;
  localparam int FRAC_FULL_SIZE = 28;
  localparam int TE_BITS        = 10;
  localparam int K_BITS         = TE_BITS - ES;

  typedef logic [N-1:0] posit_t;

  typedef struct packed {
    logic                      sign;
    logic signed [TE_BITS-1:0] total_exponent;
    logic [FRAC_FULL_SIZE-1:0] frac;
  } long_fir_t;

  typedef struct packed {
    long_fir_t long_fir;
    logic      frac_truncated;
  } ops_out_meta_t;

  typedef struct packed {
    posit_t posit;
    logic   special_tag;
  } posit_special_t;

  typedef struct packed {
    logic                      sign;
    logic signed [K_BITS-1:0]  k;
    logic [ES-1:0]             e;
    logic [FRAC_FULL_SIZE-1:0] frac;
    logic                      sticky;
    logic                      sat_max;
    logic                      sat_min;
    posit_special_t            special;
  } round_s1_t;

  localparam posit_t ZERO   = {N{1'b0}};
  localparam posit_t NAR    = {1'b1, {(N-1){1'b0}}};
  localparam posit_t MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam posit_t MINPOS = {{(N-1){1'b0}}, 1'b1};

  function automatic posit_t c2(input posit_t x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/posit_rne_pack.sv
// Combinational regime/exponent/fraction assembly with round-to-nearest-even,
// saturation clamping, sign application and special-value bypass.
module posit_rne_pack
  import ppu_pkg::*;
(
  input  round_s1_t s1,
  output posit_t    posit
);

  localparam int SW = 1 + ES + FRAC_FULL_SIZE;
  localparam int VW = (N - 2) + SW;

  logic [SW-1:0]     tail;
  logic [VW-1:0]     fill;
  logic [VW-1:0]     str;
  logic [K_BITS-1:0] run;
  logic [N-2:0]      m;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [N-1:0]      sum;
  posit_t            mag;

  // Regime run is k+1 ones for k>=0 or -k zeros for k<0; the terminator is the
  // inverse of the run bit, so it equals the sign of k.
  always_comb begin
    run = '0;
    if (s1.k[K_BITS-1]) begin
      run = ~s1.k + {{(K_BITS-1){1'b0}}, 1'b1};
    end else begin
      run = s1.k + {{(K_BITS-1){1'b0}}, 1'b1};
    end
    tail = {s1.k[K_BITS-1], s1.e, s1.frac};
    if (s1.k[K_BITS-1]) begin
      fill = {VW{1'b0}};
    end else begin
      fill = ~({VW{1'b1}} >> run);
    end
    str    = fill | ({tail, {(N-2){1'b0}}} >> run);
    m      = str[VW-1 -: N-1];
    guard  = str[VW-N];
    sticky = (|str[VW-N-1:0]) | s1.sticky;
    inc    = guard & (m[0] | sticky);
    sum    = {1'b0, m} + {{(N-1){1'b0}}, inc};
    if (s1.sat_max) begin
      mag = MAXPOS;
    end else if (s1.sat_min) begin
      mag = MINPOS;
    end else if (sum[N-1]) begin
      mag = MAXPOS;
    end else if (sum == {N{1'b0}}) begin
      mag = MINPOS;
    end else begin
      mag = sum;
    end
    if (s1.special.special_tag) begin
      posit = s1.special.posit;
    end else if (s1.sign) begin
      posit = c2(mag);
    end else begin
      posit = mag;
    end
  end

endmodule

// File: rtl/posit_round_encode.sv
// Two-stage elastic output stage: S1 decodes regime/exponent and saturation,
// S2 registers the rounded, signed posit.
module posit_round_encode
  import ppu_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  ops_out_meta_t  ops_meta_i,
  input  posit_special_t special_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output posit_t         posit_o
);

  localparam logic signed [TE_BITS-1:0] K_SAT_HI = TE_BITS'(N - 2);
  localparam logic signed [TE_BITS-1:0] K_SAT_LO = TE_BITS'(1 - N);

  logic                      s1_valid;
  logic                      s2_valid;
  logic                      s1_adv;
  logic                      s2_adv;
  logic signed [TE_BITS-1:0] k_full;
  round_s1_t                 s1_d;
  round_s1_t                 s1_q;
  posit_t                    packed_posit;
  posit_t                    posit_q;

  assign s2_adv      = !s2_valid | out_ready_i;
  assign s1_adv      = !s1_valid | s2_adv;
  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid;
  assign posit_o     = posit_q;

  assign k_full = $signed(ops_meta_i.long_fir.total_exponent) >>> ES;

  // Stage-1 decode of the incoming fir into regime, exponent and saturation flags.
  always_comb begin
    s1_d         = {$bits(round_s1_t){1'b0}};
    s1_d.sign    = ops_meta_i.long_fir.sign;
    s1_d.k       = k_full[K_BITS-1:0];
    s1_d.e       = ops_meta_i.long_fir.total_exponent[ES-1:0];
    s1_d.frac    = ops_meta_i.long_fir.frac;
    s1_d.sticky  = ops_meta_i.frac_truncated;
    s1_d.sat_max = (k_full >= K_SAT_HI);
    s1_d.sat_min = (k_full <= K_SAT_LO);
    s1_d.special = special_i;
  end

  // Stage-1 register: loads only on an input transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_q     <= {$bits(round_s1_t){1'b0}};
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_q <= s1_d;
      end
    end
  end

  posit_rne_pack u_pack (
    .s1    (s1_q),
    .posit (packed_posit)
  );

  // Stage-2 register: output is held stable while downstream stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      posit_q  <= {N{1'b0}};
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        posit_q <= packed_posit;
      end
    end
  end

endmodule
